l2_core_request_arbiter: RTL and testbench

- Shares the single L2 request port between NUM_CORES core instances.
- Each core's combined l2req_* stream, i.e. the output of its per-core arbiter mux, feeds one requester slot.
- Round-robin grant with a one-entry registered output stage toward the L2 cache.
- Tags each forwarded request with the originating core index, so L2 responses can be routed back through l2rsp_core.

---
 rtl/l2_core_request_arbiter_pkg.sv | 28 ++
 rtl/l2_core_request_arbiter_if.sv | 47 ++++
 rtl/l2_core_request_arbiter_rr_priority_arbiter.sv | 57 +++++
 rtl/l2_core_request_arbiter.sv | 126 ++++++++++++
 tb/tb_l2_core_request_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_core_request_arbiter_pkg.sv
// Shared widths and the request bundle for the L2 core request arbiter.
// CORE_INDEX_WIDTH normally comes from l2_cache.h; a standalone default is provided.
`ifndef CORE_INDEX_WIDTH
`define CORE_INDEX_WIDTH 2
`endif

package l2_core_request_arbiter_pkg;

    localparam int CORE_IDX_W = `CORE_INDEX_WIDTH;
    localparam int STRAND_W   = 2;
    localparam int UNIT_W     = 2;
    localparam int OP_W       = 3;
    localparam int WAY_W      = 2;
    localparam int ADDR_W     = 26;
    localparam int DATA_W     = 512;
    localparam int MASK_W     = 64;

    typedef struct packed {
        logic [STRAND_W-1:0] strand;
        logic [UNIT_W-1:0]   unit;
        logic [OP_W-1:0]     op;
        logic [WAY_W-1:0]    way;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic [MASK_W-1:0]   mask;
    } l2req_t;

endpackage

// File: rtl/l2_core_request_arbiter_if.sv
// Core-side request slots and the shared L2 request port.
// master: the arbiter; slave: the cores plus the L2 cache.
interface l2_core_request_arbiter_if #(
    parameter int NUM_CORES = 4
);
    import l2_core_request_arbiter_pkg::*;

    logic [NUM_CORES-1:0]          core_l2req_valid;
    logic [NUM_CORES-1:0]          core_l2req_ready;
    logic [STRAND_W*NUM_CORES-1:0] core_l2req_strand;
    logic [UNIT_W*NUM_CORES-1:0]   core_l2req_unit;
    logic [OP_W*NUM_CORES-1:0]     core_l2req_op;
    logic [WAY_W*NUM_CORES-1:0]    core_l2req_way;
    logic [ADDR_W*NUM_CORES-1:0]   core_l2req_address;
    logic [DATA_W*NUM_CORES-1:0]   core_l2req_data;
    logic [MASK_W*NUM_CORES-1:0]   core_l2req_mask;

    logic                  l2req_valid;
    logic                  l2req_ready;
    logic [CORE_IDX_W-1:0] l2req_core;
    logic [STRAND_W-1:0]   l2req_strand;
    logic [UNIT_W-1:0]     l2req_unit;
    logic [OP_W-1:0]       l2req_op;
    logic [WAY_W-1:0]      l2req_way;
    logic [ADDR_W-1:0]     l2req_address;
    logic [DATA_W-1:0]     l2req_data;
    logic [MASK_W-1:0]     l2req_mask;

    modport master (
        input  core_l2req_valid, core_l2req_strand, core_l2req_unit,
        input  core_l2req_op, core_l2req_way, core_l2req_address,
        input  core_l2req_data, core_l2req_mask, l2req_ready,
        output core_l2req_ready, l2req_valid, l2req_core,
        output l2req_strand, l2req_unit, l2req_op, l2req_way,
        output l2req_address, l2req_data, l2req_mask
    );

    modport slave (
        output core_l2req_valid, core_l2req_strand, core_l2req_unit,
        output core_l2req_op, core_l2req_way, core_l2req_address,
        output core_l2req_data, core_l2req_mask, l2req_ready,
        input  core_l2req_ready, l2req_valid, l2req_core,
        input  l2req_strand, l2req_unit, l2req_op, l2req_way,
        input  l2req_address, l2req_data, l2req_mask
    );

endinterface

// File: rtl/l2_core_request_arbiter_rr_priority_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer wins,
// pointer moves past the winner only when update_lru_i allows a grant.
module rr_priority_arbiter #(
    parameter int NUM_REQUESTERS = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQUESTERS-1:0]         request_i,
    input  logic                              update_lru_i,
    output logic [NUM_REQUESTERS-1:0]         grant_oh_o,
    output logic [$clog2(NUM_REQUESTERS)-1:0] ptr_o
);

    localparam int PTR_W = $clog2(NUM_REQUESTERS);

    logic [PTR_W-1:0] ptr_q, ptr_d, win;
    logic [PTR_W:0]   idx;
    logic             found;

    always_comb begin
        grant_oh_o = '0;
        ptr_d      = ptr_q;
        found      = 1'b0;
        win        = '0;
        idx        = '0;
        // Wrap by compare-and-subtract so non-power-of-two counts work.
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQUESTERS)) begin
                idx = idx - (PTR_W+1)'(NUM_REQUESTERS);
            end
            if (!found && request_i[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
        if (found && update_lru_i) begin
            grant_oh_o[win] = 1'b1;
            if (win == PTR_W'(NUM_REQUESTERS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/l2_core_request_arbiter.sv
// Shares the L2 request port between NUM_CORES cores, tagging each request with its core.
// Optional build macro: L2_ARB_PERF_EVENTS_EN enables the conflict/stall event pulses.
module l2_core_request_arbiter
    import l2_core_request_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    l2_core_request_arbiter_if.master bus,
    output logic                      pc_event_l2_arb_conflict,
    output logic                      pc_event_l2_arb_stall
);

    localparam int PTR_W = $clog2(NUM_CORES);

    logic                  load_en;
    logic [NUM_CORES-1:0]  grant;
    logic [PTR_W-1:0]      arb_ptr;
    l2req_t                sel;
    l2req_t                out_q, out_d;
    logic [CORE_IDX_W-1:0] sel_core;
    logic [CORE_IDX_W-1:0] core_q, core_d;
    logic                  valid_q, valid_d;

    assign load_en = !valid_q || bus.l2req_ready;

    rr_priority_arbiter #(
        .NUM_REQUESTERS(NUM_CORES)
    ) u_rr (
        .clk         (clk),
        .reset       (reset),
        .request_i   (bus.core_l2req_valid),
        .update_lru_i(load_en),
        .grant_oh_o  (grant),
        .ptr_o       (arb_ptr)
    );

    assign bus.core_l2req_ready = grant;

    always_comb begin
        sel      = '0;
        sel_core = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sel.strand  |= {STRAND_W{grant[i]}}
                         & bus.core_l2req_strand[i*STRAND_W +: STRAND_W];
            sel.unit    |= {UNIT_W{grant[i]}}
                         & bus.core_l2req_unit[i*UNIT_W +: UNIT_W];
            sel.op      |= {OP_W{grant[i]}}
                         & bus.core_l2req_op[i*OP_W +: OP_W];
            sel.way     |= {WAY_W{grant[i]}}
                         & bus.core_l2req_way[i*WAY_W +: WAY_W];
            sel.address |= {ADDR_W{grant[i]}}
                         & bus.core_l2req_address[i*ADDR_W +: ADDR_W];
            sel.data    |= {DATA_W{grant[i]}}
                         & bus.core_l2req_data[i*DATA_W +: DATA_W];
            sel.mask    |= {MASK_W{grant[i]}}
                         & bus.core_l2req_mask[i*MASK_W +: MASK_W];
            sel_core    |= {CORE_IDX_W{grant[i]}} & CORE_IDX_W'(i);
        end
    end

    // A grant only happens when the slot is free or retiring, so reload wins.
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        core_d  = core_q;
        if (|grant) begin
            valid_d = 1'b1;
            out_d   = sel;
            core_d  = sel_core;
        end else if (bus.l2req_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            out_q   <= '0;
            core_q  <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
            core_q  <= core_d;
        end
    end

    assign bus.l2req_valid   = valid_q;
    assign bus.l2req_core    = core_q;
    assign bus.l2req_strand  = out_q.strand;
    assign bus.l2req_unit    = out_q.unit;
    assign bus.l2req_op      = out_q.op;
    assign bus.l2req_way     = out_q.way;
    assign bus.l2req_address = out_q.address;
    assign bus.l2req_data    = out_q.data;
    assign bus.l2req_mask    = out_q.mask;

    ptr_in_range: assert property (@(posedge clk) disable iff (reset)
        {1'b0, arb_ptr} < (PTR_W+1)'(NUM_CORES));

`ifdef L2_ARB_PERF_EVENTS_EN
    logic conflict_q, stall_q, multi_req;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_req = |(bus.core_l2req_valid
                       & (bus.core_l2req_valid - NUM_CORES'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            conflict_q <= (|grant) && multi_req;
            stall_q    <= valid_q && !bus.l2req_ready;
        end
    end

    assign pc_event_l2_arb_conflict = conflict_q;
    assign pc_event_l2_arb_stall    = stall_q;
`else
    assign pc_event_l2_arb_conflict = 1'b0;
    assign pc_event_l2_arb_stall    = 1'b0;
`endif

endmodule

// File: tb/tb_l2_core_request_arbiter.sv
// Scoreboard bench for l2_core_request_arbiter: a round-robin model predicts
// grants, granted requests are queued and popped as the L2 port retires them.
module tb_l2_core_request_arbiter;
    import l2_core_request_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int PKT_W = CORE_IDX_W + $bits(l2req_t);

    logic clk = 1'b0;
    logic reset;
    logic pc_conf, pc_stall;

    always #5 clk = ~clk;

    l2_core_request_arbiter_if #(.NUM_CORES(N)) bus ();

    l2_core_request_arbiter #(.NUM_CORES(N)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .bus                     (bus),
        .pc_event_l2_arb_conflict(pc_conf),
        .pc_event_l2_arb_stall   (pc_stall)
    );

    logic [N-1:0] vld;
    logic [N-1:0] keep;
    l2req_t       req [N];
    logic         l2rdy;

    always_comb begin
        bus.core_l2req_valid = vld;
        bus.l2req_ready      = l2rdy;
        bus.core_l2req_strand  = '0;
        bus.core_l2req_unit    = '0;
        bus.core_l2req_op      = '0;
        bus.core_l2req_way     = '0;
        bus.core_l2req_address = '0;
        bus.core_l2req_data    = '0;
        bus.core_l2req_mask    = '0;
        for (int i = 0; i < N; i++) begin
            bus.core_l2req_strand[i*STRAND_W +: STRAND_W] = req[i].strand;
            bus.core_l2req_unit[i*UNIT_W +: UNIT_W]       = req[i].unit;
            bus.core_l2req_op[i*OP_W +: OP_W]             = req[i].op;
            bus.core_l2req_way[i*WAY_W +: WAY_W]          = req[i].way;
            bus.core_l2req_address[i*ADDR_W +: ADDR_W]    = req[i].address;
            bus.core_l2req_data[i*DATA_W +: DATA_W]       = req[i].data;
            bus.core_l2req_mask[i*MASK_W +: MASK_W]       = req[i].mask;
        end
    end

    int               n_chk  = 0;
    int               n_fail = 0;
    logic             m_valid;
    int               m_ptr;
    logic             m_conf, m_stall;
    logic [PKT_W-1:0] sb [$];
    int               last_grant;

    task automatic chk_eq(input string tag, input logic [639:0] act,
                          input logic [639:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic l2req_t mk_req(input logic [25:0] addr,
                                      input logic [2:0] op);
        l2req_t r;
        r.strand  = addr[1:0];
        r.unit    = addr[3:2];
        r.op      = op;
        r.way     = addr[5:4];
        r.address = addr;
        r.data    = {16{~32'(addr) ^ 32'h5a5a_0000}};
        r.mask    = {~32'(addr), 32'(addr)};
        return r;
    endfunction

    function automatic logic [PKT_W-1:0] out_pkt();
        return {bus.l2req_core, bus.l2req_strand, bus.l2req_unit,
                bus.l2req_op, bus.l2req_way, bus.l2req_address,
                bus.l2req_data, bus.l2req_mask};
    endfunction

    task automatic set_core(input int i, input logic [25:0] addr,
                            input logic [2:0] op);
        vld[i] = 1'b1;
        req[i] = mk_req(addr, op);
    endtask

    // One clock: check current outputs, advance model, cross the edge.
    task automatic cycle();
        logic [N-1:0] eg;
        logic         load;
        int           k;
        #1;
        load = !m_valid || l2rdy;
        eg   = '0;
        k    = -1;
        if (load) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (k < 0 && vld[c]) k = c;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        chk_eq("core_ready", bus.core_l2req_ready, eg);
        chk_eq("l2req_valid", bus.l2req_valid, m_valid);
        chk_eq("pointer", dut.arb_ptr, m_ptr);
        chk_eq("ev_conflict", pc_conf, m_conf);
        chk_eq("ev_stall", pc_stall, m_stall);
        if (m_valid) begin
            chk_eq("sb_depth", sb.size(), 1);
            if (sb.size() != 0) chk_eq("l2req_pkt", out_pkt(), sb[0]);
        end
        if (reset) begin
            sb.delete();
            m_valid = 1'b0;
            m_ptr   = 0;
            m_conf  = 1'b0;
            m_stall = 1'b0;
        end else begin
`ifdef L2_ARB_PERF_EVENTS_EN
            m_conf  = (k >= 0) && ($countones(vld) >= 2);
            m_stall = m_valid && !l2rdy;
`endif
            if (m_valid && l2rdy && sb.size() != 0) void'(sb.pop_front());
            if (k >= 0) begin
                sb.push_back({CORE_IDX_W'(k), req[k]});
                m_valid = 1'b1;
                m_ptr   = (k + 1) % N;
            end else if (l2rdy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (k >= 0) begin
            if (keep[k]) req[k] = mk_req(req[k].address + 26'h40, req[k].op);
            else vld[k] = 1'b0;
        end
        last_grant = k;
    endtask

    task automatic do_reset();
        vld   = '0;
        keep  = '0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        vld   = '0;
        keep  = '0;
        l2rdy = 1'b0;
        for (int i = 0; i < N; i++) req[i] = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0;
        m_ptr   = 0;
        m_conf  = 1'b0;
        m_stall = 1'b0;
        last_grant = -1;
        #1;
        chk_eq("rst_valid", bus.l2req_valid, 1'b0);
        chk_eq("rst_core", bus.l2req_core, 0);
        chk_eq("rst_addr", bus.l2req_address, 0);
        chk_eq("rst_data", bus.l2req_data, 0);
        chk_eq("rst_ptr", dut.arb_ptr, 0);
        chk_eq("rst_conf", pc_conf, 1'b0);
        chk_eq("rst_stall", pc_stall, 1'b0);
        reset = 1'b0;

        // Lone core 2.
        l2rdy = 1'b1;
        set_core(2, 26'h0000123, 3'd1);
        cycle();
        chk_eq("lone_grant", last_grant, 2);
        #1;
        chk_eq("lone_valid", bus.l2req_valid, 1'b1);
        chk_eq("lone_core", bus.l2req_core, 2);
        chk_eq("lone_addr", bus.l2req_address, 26'h0000123);
        chk_eq("lone_op", bus.l2req_op, 3'd1);
        cycle();

        // All four continuously valid.
        do_reset();
        l2rdy = 1'b1;
        keep  = '1;
        for (int i = 0; i < N; i++) set_core(i, 26'(32'h1000 * (i + 1)), 3'(i));
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk_eq("rr_order", last_grant, c % N);
        end
        keep = '0;
        vld  = '0;
        repeat (2) cycle();

        // Stall with core 1 held, cores 0 and 3 waiting.
        do_reset();
        l2rdy = 1'b1;
        set_core(1, 26'h0000a11, 3'd2);
        cycle();
        l2rdy = 1'b0;
        set_core(0, 26'h0000b00, 3'd3);
        set_core(3, 26'h0000b33, 3'd4);
        repeat (3) cycle();
        l2rdy = 1'b1;
        cycle();
        chk_eq("stall_release", last_grant, 3);
        cycle();
        chk_eq("after_release", last_grant, 0);
        repeat (2) cycle();

        // Wrap-around from pointer 3.
        do_reset();
        l2rdy = 1'b1;
        set_core(2, 26'h0000222, 3'd0);
        cycle();
        set_core(0, 26'h0000c00, 3'd5);
        set_core(1, 26'h0000c11, 3'd6);
        cycle();
        chk_eq("wrap_grant0", last_grant, 0);
        cycle();
        chk_eq("wrap_grant1", last_grant, 1);
        repeat (2) cycle();

        // Reset while the slot is stalled.
        do_reset();
        l2rdy = 1'b0;
        set_core(0, 26'h0000d00, 3'd7);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        chk_eq("midrst_valid", bus.l2req_valid, 1'b0);
        chk_eq("midrst_core", bus.l2req_core, 0);
        chk_eq("midrst_ptr", dut.arb_ptr, 0);
        l2rdy = 1'b1;
        repeat (2) cycle();

        // Event pulses: two valid at the first grant, then stall.
        do_reset();
        l2rdy = 1'b1;
        set_core(0, 26'h0000e00, 3'd1);
        set_core(1, 26'h0000e11, 3'd2);
        cycle();
        l2rdy = 1'b0;
        repeat (2) cycle();
        l2rdy = 1'b1;
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
